// File: rtl/icache_fetch_responder_if.sv
// Fetch-side and memory-fill signals of the instruction cache, bundled as one port.
// The cache takes the slave modport; the fetch stage/memory model takes master.
interface icache_fetch_responder_if;
  logic [31:0] Instr_address_2IM;
  logic [31:0] Instr1_fIM;
  logic        miss;
  logic        Flush_IN;
  logic        Mem_Req_OUT;
  logic [31:0] Mem_Addr_OUT;
  logic        Mem_Valid_IN;
  logic [31:0] Mem_Data_IN;
  logic [31:0] Miss_Count_OUT;

  modport slave (
    input  Instr_address_2IM, Flush_IN, Mem_Valid_IN, Mem_Data_IN,
    output Instr1_fIM, miss, Mem_Req_OUT, Mem_Addr_OUT, Miss_Count_OUT
  );

  modport master (
    output Instr_address_2IM, Flush_IN, Mem_Valid_IN, Mem_Data_IN,
    input  Instr1_fIM, miss, Mem_Req_OUT, Mem_Addr_OUT, Miss_Count_OUT
  );
endinterface

// File: rtl/icache_fetch_responder.sv
// Direct-mapped instruction cache: combinational hit path, line-fill burst on miss.
// Flush during a fill poisons the line so it drains but never becomes valid.
module icache_fetch_responder #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic                           CLK,
  input  logic                           RESET,
  icache_fetch_responder_if.slave        fif
);
  localparam int WB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(NUM_LINES);
  localparam int TB = 32 - 2 - WB - IB;

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  state_t               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic                 poison_q, poison_d;
  logic [WB-1:0]        cnt_q, cnt_d;
  logic [31:0]          maddr_q, maddr_d;
  logic [31:0]          mcnt_q, mcnt_d;

  logic [31:0]          data_q [NUM_LINES][LINE_WORDS];
  logic [TB-1:0]        tag_q  [NUM_LINES];
  logic                 data_we, tag_we;

  logic [WB-1:0]        a_word;
  logic [IB-1:0]        a_idx;
  logic [TB-1:0]        a_tag;
  logic [IB-1:0]        f_idx;
  logic [TB-1:0]        f_tag;
  logic                 hit;

  assign a_word = fif.Instr_address_2IM[2 +: WB];
  assign a_idx  = fif.Instr_address_2IM[2+WB +: IB];
  assign a_tag  = fif.Instr_address_2IM[31 -: TB];
  // Fill target comes from the latched line address, not the live fetch address
  assign f_idx  = maddr_q[2+WB +: IB];
  assign f_tag  = maddr_q[31 -: TB];

  assign hit = (state_q == IDLE) && valid_q[a_idx] && (tag_q[a_idx] == a_tag);

  assign fif.miss           = !hit;
  assign fif.Instr1_fIM     = hit ? data_q[a_idx][a_word] : 32'h0;
  assign fif.Mem_Req_OUT    = (state_q == REQ);
  assign fif.Mem_Addr_OUT   = maddr_q;
  assign fif.Miss_Count_OUT = mcnt_q;

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    poison_d = poison_q;
    cnt_d    = cnt_q;
    maddr_d  = maddr_q;
    mcnt_d   = mcnt_q;
    data_we  = 1'b0;
    tag_we   = 1'b0;
    case (state_q)
      IDLE: if (!hit && !fif.Flush_IN) begin
        maddr_d = {fif.Instr_address_2IM[31:2+WB], {(2+WB){1'b0}}};
        cnt_d   = '0;
        mcnt_d  = mcnt_q + 32'd1;
        state_d = REQ;
      end
      REQ: state_d = FILL;
      FILL: if (fif.Mem_Valid_IN) begin
        data_we = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == WB'(LINE_WORDS-1)) begin
          tag_we  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fif.Flush_IN) begin
      valid_d = '0;
      if (state_q != IDLE) poison_d = 1'b1;
    end
    // A flush on the final word cycle also keeps the line invalid
    if (tag_we) begin
      if (!poison_q && !fif.Flush_IN) valid_d[f_idx] = 1'b1;
      poison_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q  <= IDLE;
      valid_q  <= '0;
      poison_q <= 1'b0;
      cnt_q    <= '0;
      maddr_q  <= '0;
      mcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      poison_q <= poison_d;
      cnt_q    <= cnt_d;
      maddr_q  <= maddr_d;
      mcnt_q   <= mcnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET && data_we) data_q[f_idx][cnt_q] <= fif.Mem_Data_IN;
    if (RESET && tag_we)  tag_q[f_idx]         <= f_tag;
  end
endmodule
